// File: rtl/rvv_pkg.sv
// rvv_pkg: shared encodings for the vector ALU sequencer.
package rvv_pkg;
    localparam logic [2:0] OP_VV = 3'b001, OP_VX = 3'b010, OP_VI = 3'b100;
    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RUN, S_FIN} seq_state_t;
    localparam logic [5:0] F6_VADD   = 6'b000000, F6_VSUB  = 6'b000010, F6_VRSUB = 6'b000011,
                           F6_VMINU  = 6'b000100, F6_VMIN  = 6'b000101, F6_VMAXU = 6'b000110,
                           F6_VMAX   = 6'b000111, F6_VAND  = 6'b001001, F6_VOR   = 6'b001010,
                           F6_VXOR   = 6'b001011, F6_VSLL  = 6'b100101, F6_VSRL  = 6'b101000,
                           F6_VSRA   = 6'b101001, F6_VMAND = 6'b011001, F6_VMNAND = 6'b011101;
endpackage

// File: rtl/rvv_alu_seq_if.sv
// rvv_alu_seq_if: issue-stage and ALU-side signals of the vector ALU sequencer.
interface rvv_alu_seq_if #(
    parameter int VLEN = 128,
    parameter int VL_W = $clog2(VLEN) + 1
);
    logic            start;
    logic [5:0]      opcode;
    logic            instr_mask;
    logic [2:0]      op_type, vsew;
    logic [VL_W-1:0] vl;
    logic [VLEN-1:0] vs1_in, vs2_in, vd_old;
    logic            busy, done, illegal, vd_we;
    logic [VLEN-1:0] vd_out;
    logic            alu_run;
    logic [5:0]      alu_opcode;
    logic            alu_instr_mask;
    logic [2:0]      alu_op_type, alu_vsew;
    logic [9:0]      alu_byte_i;
    logic [3:0]      alu_in_reg_offset;
    logic [VLEN-1:0] alu_vs1, alu_vs2;
    logic [63:0]     alu_vd;
    logic [9:0]      alu_index;
    logic            alu_instr_valid;

    modport master (
        output start, opcode, instr_mask, op_type, vsew, vl, vs1_in, vs2_in, vd_old,
               alu_vd, alu_index, alu_instr_valid,
        input  busy, done, illegal, vd_we, vd_out, alu_run, alu_opcode, alu_instr_mask,
               alu_op_type, alu_vsew, alu_byte_i, alu_in_reg_offset, alu_vs1, alu_vs2
    );
    modport slave (
        input  start, opcode, instr_mask, op_type, vsew, vl, vs1_in, vs2_in, vd_old,
               alu_vd, alu_index, alu_instr_valid,
        output busy, done, illegal, vd_we, vd_out, alu_run, alu_opcode, alu_instr_mask,
               alu_op_type, alu_vsew, alu_byte_i, alu_in_reg_offset, alu_vs1, alu_vs2
    );
endinterface

// File: rtl/rvv_seq_cnt.sv
// rvv_seq_cnt: element/chunk counter pair walking an instruction's chunks in order.
module rvv_seq_cnt #(
    parameter int VL_W = 8
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            clr,
    input  logic            step,
    input  logic [4:0]      chunks,
    input  logic [VL_W-1:0] vl_eff,
    output logic [9:0]      elem,
    output logic [3:0]      chunk,
    output logic            last
);
    logic chunk_end;

    assign chunk_end = 5'(chunk) == chunks - 5'd1;
    assign last      = chunk_end && elem == 10'(vl_eff) - 10'd1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            elem  <= '0;
            chunk <= '0;
        end else if (clr) begin
            elem  <= '0;
            chunk <= '0;
        end else if (step) begin
            chunk <= chunk_end ? 4'd0 : chunk + 4'd1;
            elem  <= chunk_end ? elem + 10'd1 : elem;
        end
    end
endmodule

// File: rtl/rvv_alu_seq.sv
// rvv_alu_seq: steps the vector ALU over every element and lane chunk, assembling vd.
module rvv_alu_seq
    import rvv_pkg::*;
#(
    parameter int VLEN       = 128,
    parameter int LANE_WIDTH = 3,
    parameter int VL_W       = $clog2(VLEN) + 1
) (
    input logic          clk,
    input logic          resetn,
    rvv_alu_seq_if.slave io
);
    seq_state_t      state;
    logic [5:0]      opcode;
    logic            instr_mask;
    logic [2:0]      op_type, vsew;
    logic [VLEN-1:0] vs1, vs2, lane_ones;
    logic [VL_W-1:0] vl_eff, bound;
    logic [3:0]      esh, wsh, chunk;
    logic [4:0]      chunks;
    logic [9:0]      elem;
    logic            last, bad;

    // Mask ops address single bits, so their element bound is VLEN itself.
    assign bound     = io.instr_mask ? VL_W'(VLEN) : VL_W'(VLEN) >> (4'(io.vsew) + 4'd3);
    assign esh       = 4'(vsew) + 4'd3;
    assign wsh       = instr_mask ? 4'd0 : (esh <= 4'(LANE_WIDTH) ? esh : 4'(LANE_WIDTH));
    assign chunks    = (instr_mask || esh <= 4'(LANE_WIDTH)) ? 5'd1 : 5'd1 << (esh - 4'(LANE_WIDTH));
    assign lane_ones = ~({VLEN{1'b1}} << (32'd1 << wsh));
    assign bad       = vsew > 3'd3 || !io.alu_instr_valid;

    assign io.alu_opcode        = opcode;
    assign io.alu_instr_mask    = instr_mask;
    assign io.alu_op_type       = op_type;
    assign io.alu_vsew          = vsew;
    assign io.alu_vs1           = vs1;
    assign io.alu_vs2           = vs2;
    assign io.alu_byte_i        = elem;
    assign io.alu_in_reg_offset = chunk;

    rvv_seq_cnt #(.VL_W(VL_W)) u_cnt (
        .clk    (clk),
        .resetn (resetn),
        .clr    (state != S_RUN),
        .step   (state == S_RUN),
        .chunks (chunks),
        .vl_eff (vl_eff),
        .elem   (elem),
        .chunk  (chunk),
        .last   (last)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            io.busy    <= 1'b0;
            io.done    <= 1'b0;
            io.illegal <= 1'b0;
            io.vd_we   <= 1'b0;
            io.alu_run <= 1'b0;
            io.vd_out  <= '0;
            opcode     <= '0;
            instr_mask <= 1'b0;
            op_type    <= '0;
            vsew       <= '0;
            vs1        <= '0;
            vs2        <= '0;
            vl_eff     <= '0;
        end else begin
            io.done  <= 1'b0;
            io.vd_we <= 1'b0;
            case (state)
                S_IDLE: if (io.start) begin
                    opcode     <= io.opcode;
                    instr_mask <= io.instr_mask;
                    op_type    <= io.op_type;
                    vsew       <= io.vsew;
                    vs1        <= io.vs1_in;
                    vs2        <= io.vs2_in;
                    vl_eff     <= io.vl < bound ? io.vl : bound;
                    io.vd_out  <= io.vd_old;
                    io.illegal <= 1'b0;
                    io.busy    <= 1'b1;
                    state      <= S_CHECK;
                end
                S_CHECK: if (bad || vl_eff == '0) begin
                    io.illegal <= bad;
                    io.vd_we   <= !bad;
                    io.done    <= 1'b1;
                    state      <= S_FIN;
                end else begin
                    io.alu_run <= 1'b1;
                    state      <= S_RUN;
                end
                S_RUN: begin
                    io.vd_out <= (io.vd_out & ~(lane_ones << io.alu_index)) |
                                 ((VLEN'(io.alu_vd) & lane_ones) << io.alu_index);
                    if (last) begin
                        io.alu_run <= 1'b0;
                        io.done    <= 1'b1;
                        io.vd_we   <= 1'b1;
                        state      <= S_FIN;
                    end
                end
                default: begin
                    io.busy <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rvv_alu_seq.sv
// tb_rvv_alu_seq: randomized bench with an instruction-level reference model and a behavioural ALU.
module tb_rvv_alu_seq;
    import rvv_pkg::*;
    localparam logic [127:0] AA   = {16{8'hAA}};
    localparam logic [127:0] ONES = {128{1'b1}};

    logic clk = 1'b0, resetn = 1'b0;
    always #5 clk = ~clk;

    rvv_alu_seq_if #(.VLEN(128)) io ();
    rvv_alu_seq #(.VLEN(128), .LANE_WIDTH(3)) dut (.clk(clk), .resetn(resetn), .io(io));

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, runs = 0, ndone = 0, n_before = 0;
    int last_cyc = 0, last_runs = 0;
    logic last_ill = 1'b0, last_we = 1'b0;
    bit trk = 0, post = 0;
    int exp_lat = 0, exp_runs = 0, exp_c = 1;
    logic exp_ill = 1'b0;
    logic [127:0] exp_vd = '0, e_a = '0, e_b = '0;
    logic [5:0] e_op = '0;
    logic e_m = 1'b0;
    logic [2:0] e_ot = '0, e_vs = '0;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    function automatic logic op_ok(input logic [5:0] op, input logic m);
        return m ? (op == F6_VMAND || op == F6_VMNAND)
                 : (op inside {F6_VADD, F6_VSUB, F6_VAND, F6_VOR, F6_VXOR});
    endfunction

    function automatic logic [127:0] iop(input logic [5:0] op, input logic [127:0] x, input logic [127:0] y);
        case (op)
            F6_VADD: return x + y;
            F6_VSUB: return x - y;
            F6_VAND: return x & y;
            F6_VOR:  return x | y;
            default: return x ^ y;
        endcase
    endfunction

    function automatic logic mop(input logic [5:0] op, input logic x, input logic y);
        return op == F6_VMNAND ? !(x && y) : (x && y);
    endfunction

    function automatic logic [127:0] elt(input logic [127:0] v, input int i, input int sew);
        return (v >> (i * sew)) & (ONES >> (128 - sew));
    endfunction

    // Whole-instruction result: body elements computed, tail left as vd_old.
    function automatic logic [127:0] ref_vd(input logic [5:0] op, input logic m, input logic [2:0] vs,
                                            input int vl, input logic [127:0] a, input logic [127:0] b,
                                            input logic [127:0] old);
        int sew, n;
        logic [127:0] r, msk;
        sew = 8 << vs;
        n = m ? 128 : 128 / sew;
        if (vl < n) n = vl;
        msk = ONES >> (128 - sew);
        r = old;
        for (int i = 0; i < n; i++)
            if (m) r[i] = mop(op, a[i], b[i]);
            else r = (r & ~(msk << (i * sew))) | ((iop(op, elt(a, i, sew), elt(b, i, sew)) & msk) << (i * sew));
        return r;
    endfunction

    // Behavioural ALU: returns the requested 8-bit chunk with junk in the unused upper bits.
    function automatic logic [63:0] alu_vd_f(input logic [5:0] op, input logic m, input logic [2:0] vs,
                                             input logic [9:0] e, input logic [3:0] c,
                                             input logic [127:0] a, input logic [127:0] b);
        int sew;
        logic [127:0] z;
        if (vs > 3) return '0;
        sew = 8 << vs;
        if (m) return {63'h2AAA_AAAA_AAAA_AAAA, mop(op, a[e[6:0]], b[e[6:0]])};
        z = iop(op, elt(a, int'(e), sew), elt(b, int'(e), sew));
        return {56'hC3C3C3C3C3C3C3, z[int'(c) * 8 +: 8]};
    endfunction

    always_comb begin
        io.alu_instr_valid = op_ok(io.alu_opcode, io.alu_instr_mask);
        io.alu_vd = alu_vd_f(io.alu_opcode, io.alu_instr_mask, io.alu_vsew, io.alu_byte_i,
                             io.alu_in_reg_offset, io.alu_vs2, io.alu_vs1);
        io.alu_index = io.alu_instr_mask ? io.alu_byte_i
                     : 10'(int'(io.alu_byte_i) * (8 << io.alu_vsew) + int'(io.alu_in_reg_offset) * 8);
    end

    always @(negedge clk) begin
        if (!resetn) begin
            trk = 0;
            post = 0;
        end else if (trk) begin
            cyc++;
            chk("busy", 128'(io.busy), 128'(1));
            chk("alu_ctl", {io.alu_opcode, io.alu_instr_mask, io.alu_op_type, io.alu_vsew}, {e_op, e_m, e_ot, e_vs});
            if (io.alu_run) begin
                chk("run_pos", {io.alu_byte_i, io.alu_in_reg_offset}, {10'(runs / exp_c), 4'(runs % exp_c)});
                runs++;
            end
            if (io.done) begin
                chk("latency", 128'(cyc), 128'(exp_lat));
                chk("runs", 128'(runs), 128'(exp_runs));
                chk("illegal", 128'(io.illegal), 128'(exp_ill));
                chk("vd_we", 128'(io.vd_we), 128'(!exp_ill));
                chk("vd_out", io.vd_out, exp_vd);
                chk("alu_vs2", io.alu_vs2, e_a);
                chk("alu_vs1", io.alu_vs1, e_b);
                last_cyc = cyc;
                last_runs = runs;
                last_ill = io.illegal;
                last_we = io.vd_we;
                trk = 0;
                post = 1;
                ndone++;
            end else begin
                chk("vd_we_early", 128'(io.vd_we), 128'(0));
                if (cyc > exp_lat) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL no_done: cycle %0d past required latency %0d", cyc, exp_lat);
                    trk = 0;
                    ndone++;
                end
            end
        end else begin
            if (post) begin
                chk("busy_drop", 128'(io.busy), 128'(0));
                chk("vd_hold", io.vd_out, exp_vd);
                post = 0;
            end
            if (io.done || io.vd_we) chk("stray_done", {io.done, io.vd_we}, 128'(0));
            if (io.start && !io.busy) begin
                trk = 1;
                cyc = 0;
                runs = 0;
            end
        end
    end

    task automatic issue(input logic [5:0] op, input logic m, input logic [2:0] ot, input logic [2:0] vs,
                         input int vl, input logic [127:0] a, input logic [127:0] b, input logic [127:0] old);
        int sew, nel;
        @(posedge clk);
        #1;
        io.opcode = op;
        io.instr_mask = m;
        io.op_type = ot;
        io.vsew = vs;
        io.vl = 8'(vl);
        io.vs2_in = a;
        io.vs1_in = b;
        io.vd_old = old;
        exp_ill = vs > 3 || !op_ok(op, m);
        sew = 8 << vs;
        nel = exp_ill ? 0 : (m ? 128 : 128 / sew);
        if (vl < nel) nel = vl;
        exp_c = m ? 1 : sew / 8;
        exp_runs = nel * exp_c;
        exp_lat = 2 + exp_runs;
        exp_vd = exp_ill ? old : ref_vd(op, m, vs, vl, a, b, old);
        {e_op, e_m, e_ot, e_vs, e_a, e_b} = {op, m, ot, vs, a, b};
        n_before = ndone;
        io.start = 1'b1;
        @(posedge clk);
        #1 io.start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400 && ndone == n_before; i++) @(negedge clk);
        if (ndone == n_before) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: no done within 400 cycles");
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [5:0] iops [5];
        iops = '{F6_VADD, F6_VSUB, F6_VAND, F6_VOR, F6_VXOR};
        io.start = 1'b0;
        io.opcode = '0;
        io.instr_mask = 1'b0;
        io.op_type = OP_VV;
        io.vsew = '0;
        io.vl = '0;
        io.vs1_in = '0;
        io.vs2_in = '0;
        io.vd_old = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_flags", {io.busy, io.done, io.illegal, io.vd_we, io.alu_run}, 128'(0));
        chk("rst_vd", io.vd_out, '0);
        chk("rst_pos", {io.alu_byte_i, io.alu_in_reg_offset, io.alu_opcode}, 128'(0));
        resetn = 1'b1;

        issue(F6_VADD, 1'b0, OP_VV, 3'd0, 4, 128'h10_20_FF_01, 128'h01_01_01_01, AA);
        chk("tp1_model", exp_vd, 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_11210002);
        wait_done();
        chk("tp1_vd", io.vd_out, 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_11210002);
        chk("tp1_lat", 128'(last_cyc), 128'(6));

        issue(F6_VADD, 1'b0, OP_VV, 3'd2, 2, 128'hFFFFFFFF_000000FF, 128'h00000001_00000001, AA);
        chk("tp2_model", exp_vd, 128'hAAAAAAAA_AAAAAAAA_00000000_00000100);
        wait_done();
        chk("tp2_vd", io.vd_out, 128'hAAAAAAAA_AAAAAAAA_00000000_00000100);
        chk("tp2_lat", 128'(last_cyc), 128'(10));

        issue(F6_VXOR, 1'b0, OP_VX, 3'd1, 0, rnd128(), rnd128(), AA);
        wait_done();
        chk("vl0", {io.vd_out, 94'(last_runs), 32'(last_cyc), last_we, last_ill}, {AA, 94'(0), 32'(2), 1'b1, 1'b0});

        issue(F6_VADD, 1'b0, OP_VV, 3'd1, 40, rnd128(), rnd128(), rnd128());
        wait_done();
        chk("clamp", {96'(last_runs), 32'(last_cyc)}, {96'(16), 32'(18)});

        issue(6'b111111, 1'b0, OP_VV, 3'd0, 4, rnd128(), rnd128(), AA);
        wait_done();
        chk("bad_op", {io.vd_out, 30'(last_cyc), last_we, last_ill}, {AA, 30'(2), 1'b0, 1'b1});

        issue(F6_VADD, 1'b0, OP_VI, 3'd5, 4, rnd128(), rnd128(), AA);
        wait_done();
        chk("bad_sew", {io.vd_out, 30'(last_cyc), last_we, last_ill}, {AA, 30'(2), 1'b0, 1'b1});

        issue(F6_VMAND, 1'b1, OP_VV, 3'd0, 5, ONES, 128'h15, ONES);
        wait_done();
        chk("vmand", io.vd_out, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFF5);
        chk("vmand_runs", 128'(last_runs), 128'(5));

        issue(F6_VSUB, 1'b0, OP_VV, 3'd3, 2, rnd128(), rnd128(), rnd128());
        repeat (4) @(posedge clk);
        #1;
        io.opcode = F6_VXOR;
        io.vs1_in = rnd128();
        io.vs2_in = rnd128();
        io.vd_old = rnd128();
        io.start = 1'b1;
        @(posedge clk);
        #1 io.start = 1'b0;
        wait_done();

        issue(F6_VADD, 1'b0, OP_VV, 3'd0, 16, rnd128(), rnd128(), rnd128());
        repeat (5) @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        chk("mid_rst_flags", {io.busy, io.done, io.illegal, io.vd_we, io.alu_run}, 128'(0));
        chk("mid_rst_vd", io.vd_out, '0);
        chk("mid_rst_vs", io.alu_vs2 | io.alu_vs1, '0);
        @(posedge clk);
        #1 resetn = 1'b1;
        repeat (4) @(posedge clk);
        issue(F6_VOR, 1'b0, OP_VV, 3'd1, 5, rnd128(), rnd128(), rnd128());
        wait_done();

        for (int k = 0; k < 40; k++) begin
            logic m;
            logic [5:0] op;
            logic [2:0] vs, ot;
            int sel, vl;
            sel = $urandom_range(0, 15);
            m = sel >= 12 && sel < 15;
            op = sel == 15 ? 6'b111111 : m ? (sel[0] ? F6_VMAND : F6_VMNAND) : iops[sel % 5];
            vs = $urandom_range(0, 9) == 0 ? 3'd5 : 3'($urandom_range(0, 3));
            vl = $urandom_range(0, 3) == 0 ? $urandom_range(0, 140) : $urandom_range(0, 17);
            ot = 3'(1 << $urandom_range(0, 2));
            issue(op, m, ot, vs, vl, rnd128(), rnd128(), rnd128());
            wait_done();
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
